serial_frame_rx: RTL
====================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 4, giving the number of received-byte FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 Port clk, input, 1 bit: the single clock, which is also the bit clock; all logic is on its rising edge.
REQ-003 Port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 Port cs, input, 1 bit: frame select, active-high; a frame is one continuous cs=1 interval.
REQ-005 Port data_in, input, 1 bit: serial data, sampled on each clk rising edge while cs=1.
REQ-006 Port rx_data, output, 8 bits: byte at the FIFO head.
REQ-007 Port rx_sof, output, 1 bit: the head byte is the first byte of its frame.
REQ-008 Port rx_valid, output, 1 bit: the FIFO is non-empty.
REQ-009 Port rx_ready, input, 1 bit: the consumer accepts the head byte.
REQ-010 Port overflow, output, 1 bit: sticky flag, set when a completed byte was dropped because the FIFO was full.
REQ-011 Port frame_err, output, 1 bit: one-cycle pulse when cs fell with a partial byte in the shifter.
REQ-012 Port parity_err, output, 1 bit: one-cycle pulse on a parity mismatch (see REQ-030).

Function
REQ-013 While cs=1, each clk edge SHALL shift data_in into the shifter MSB-first and increment the bit counter.
REQ-014 While cs=0, data_in SHALL be ignored and the bit counter SHALL be held at 0.
REQ-015 A byte SHALL complete on the edge that samples its last bit; on that same edge it is written to the FIFO and the bit counter returns to 0.
REQ-016 Latency: rx_valid SHALL be 1 in the cycle immediately after the completing edge when the FIFO was empty.
REQ-017 A completed byte SHALL carry sof=1 if it is the first byte completed since cs rose; otherwise sof=0.
REQ-018 A pop SHALL occur on an edge where rx_valid=1 and rx_ready=1; rx_data and rx_sof then advance to the next entry.
REQ-019 rx_data and rx_sof SHALL remain stable while rx_valid=1 and rx_ready=0.
REQ-020 Push while the FIFO is full with no pop in the same cycle: the byte SHALL be dropped and overflow set.
REQ-021 Push and pop in the same cycle on a full FIFO SHALL both succeed, with no overflow.
REQ-022 Push and pop in the same cycle on a non-empty FIFO SHALL leave the occupancy unchanged.
REQ-023 overflow SHALL stay at 1 until reset.
REQ-024 cs falling with bit counter ≠ 0: the partial byte SHALL be discarded, the counter cleared, and frame_err pulsed for one cycle.
REQ-025 cs falling with bit counter = 0 SHALL produce no error.
REQ-026 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, with an extra wrap bit used to distinguish full from empty.
REQ-027 Bytes in the FIFO SHALL survive cs transitions and are drained normally.

Reset
REQ-028 While reset_n=0 at a clk edge, the FIFO SHALL be emptied, the bit counter and shifter cleared, and the SOF-pending state cleared; reset applied mid-byte or mid-frame discards all state.
REQ-029 Reset output values SHALL be: rx_valid=0, rx_data=0x00, rx_sof=0, overflow=0, frame_err=0, parity_err=0.

Configuration
REQ-030 With SERIAL_RX_PARITY_EN defined:
- each byte is 9 bits: 8 data bits MSB-first, then one even-parity bit;
- on a mismatch the byte SHALL be dropped (not pushed), parity_err pulsed for one cycle, and SOF status carried to the next byte.
REQ-031 Without SERIAL_RX_PARITY_EN: each byte is 8 bits, parity_err SHALL be tied to 0, and no parity logic is synthesised.

Verification
REQ-032 Basic frame: cs=1, serial bits 1010_0101, rx_ready=1 -> one cycle after the 8th edge, rx_valid=1, rx_data=0xA5, rx_sof=1; popped on the next edge.
REQ-033 Frame of 0x11, 0x22, 0x33 with rx_ready=0 -> FIFO holds 3 entries; on release of rx_ready, output order is 0x11 (sof=1), 0x22 (sof=0), 0x33 (sof=0).
REQ-034 Overflow: FIFO_DEPTH=4, 5 bytes sent with rx_ready=0 -> overflow=1, 5th byte lost, first 4 bytes drain intact; a 6th byte completing on the same edge as a pop is accepted.
REQ-035 cs dropped after 3 bits -> frame_err pulses for exactly one cycle, nothing is pushed; the next frame's first byte has sof=1.
REQ-036 Parity (macro defined): 0xA5 with parity bit 1 -> parity_err pulses, no push; 0xA5 with parity bit 0 -> pushed normally.
REQ-037 reset_n=0 mid-byte with 2 bytes queued -> next cycle rx_valid=0 and overflow=0; a fresh byte afterwards is received correctly with sof=1.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Serial byte receiver: MSB-first shifter clocked by clk while cs=1, feeding a small
// FIFO with per-byte start-of-frame tags. Optional even parity via SERIAL_RX_PARITY_EN.
module serial_frame_rx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs,
    input  logic       data_in,
    output logic [7:0] rx_data,
    output logic       rx_sof,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overflow,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef SERIAL_RX_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif
    // The last serial bit is never stored: it is taken straight from data_in.
    localparam int SW = NBITS - 1;
    localparam logic [3:0] LAST_BIT = 4'(NBITS - 1);

    logic [3:0]    r_bit_cnt;
    logic [SW-1:0] r_shift;
    logic          r_got_byte;
    logic          r_frame_err;
    logic          r_overflow;
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [7:0]    r_mem_data [FIFO_DEPTH];
    logic          r_mem_sof  [FIFO_DEPTH];

    logic       w_done;
    logic [7:0] w_byte;
    logic       w_par_ok;
    logic       w_push_req;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;

    assign w_done = cs && (r_bit_cnt == LAST_BIT);

`ifdef SERIAL_RX_PARITY_EN
    logic r_parity_err;

    assign w_byte     = r_shift;
    assign w_par_ok   = ~(^{r_shift, data_in});
    assign parity_err = r_parity_err;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_done && !w_par_ok;
        end
    end
`else
    assign w_byte     = {r_shift, data_in};
    assign w_par_ok   = 1'b1;
    assign parity_err = 1'b0;
`endif

    assign w_push_req = w_done && w_par_ok;
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop      = !w_empty && rx_ready;
    // A pop in the same cycle frees the slot the incoming byte needs.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_got_byte  <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (cs) begin
            r_shift     <= {r_shift[SW-2:0], data_in};
            r_bit_cnt   <= w_done ? 4'd0 : r_bit_cnt + 4'd1;
            r_frame_err <= 1'b0;
            // A parity-rejected byte leaves the SOF tag for the next byte.
            if (w_push_req) begin
                r_got_byte <= 1'b1;
            end
        end else begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_got_byte  <= 1'b0;
            r_frame_err <= (r_bit_cnt != 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && w_push) begin
            r_mem_data[r_wr_ptr[AW-1:0]] <= w_byte;
            r_mem_sof[r_wr_ptr[AW-1:0]]  <= !r_got_byte;
        end
    end

    // Head is gated so the outputs read zero whenever the FIFO is empty.
    assign rx_valid  = !w_empty;
    assign rx_data   = w_empty ? 8'h00 : r_mem_data[r_rd_ptr[AW-1:0]];
    assign rx_sof    = w_empty ? 1'b0  : r_mem_sof[r_rd_ptr[AW-1:0]];
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule
